// File: rtl/phy_tx_ctrl.sv
// rtl/phy_tx_ctrl.sv - transmit sequencer feeding the OSERDES wrapper
//
// Purpose: after reset, holds the serializer in reset, then sends a training
// pattern, then frames payload from a valid/ready source as one sync word
// followed by FRAME_LEN payload words, with idle words between frames.
//
// Ports:
//   clk_div_in        parallel-word clock (only clock)
//   reset_n           synchronous active-low reset
//   enable            link enable
//   s_data/s_valid    payload word source
//   s_ready           payload accepted on s_valid && s_ready (high only in FRAME)
//   data_from_fabric  registered parallel word to the serializer
//   serdes_rst        serializer reset, active-high
//   link_up           training complete (IDLE, SYNC or FRAME)
//   underrun          one-cycle pulse per missing payload word
//   frame_cnt         completed frame count, wraps
module phy_tx_ctrl #(
   parameter int                    DATA_WIDTH   = 8,
   parameter int                    RST_CYCLES   = 16,
   parameter int                    TRAIN_CYCLES = 64,
   parameter int                    FRAME_LEN    = 16,
   parameter logic [DATA_WIDTH-1:0] TRAIN_WORD   = 8'hF0,
   parameter logic [DATA_WIDTH-1:0] SYNC_WORD    = 8'hBC,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD    = 8'h3C
) (
   input  logic                  clk_div_in,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] data_from_fabric,
   output logic                  serdes_rst,
   output logic                  link_up,
   output logic                  underrun,
   output logic [15:0]           frame_cnt
);

   localparam int CNT_MAX = (RST_CYCLES > TRAIN_CYCLES) ? RST_CYCLES : TRAIN_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int WC_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_CYCLES - 1);
   localparam logic [WC_W-1:0]  WORD_LAST  = WC_W'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      ST_RST,
      ST_TRAIN,
      ST_IDLE,
      ST_SYNC,
      ST_FRAME
   } state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [WC_W-1:0]       word_cnt, word_cnt_nxt;
   logic [DATA_WIDTH-1:0] data_q, data_nxt;
   logic                  underrun_q, underrun_nxt;
   logic [15:0]           frame_cnt_q, frame_cnt_nxt;

   // Status outputs decode straight from the state register, so s_ready
   // carries no combinational dependency on s_valid.
   assign serdes_rst       = (state == ST_RST);
   assign link_up          = (state == ST_IDLE) || (state == ST_SYNC) || (state == ST_FRAME);
   assign s_ready          = (state == ST_FRAME);
   assign data_from_fabric = data_q;
   assign underrun         = underrun_q;
   assign frame_cnt        = frame_cnt_q;

   always_ff @(posedge clk_div_in) begin
      if (!reset_n) begin
         state       <= ST_RST;
         cnt         <= '0;
         word_cnt    <= '0;
         data_q      <= '0;
         underrun_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         word_cnt    <= word_cnt_nxt;
         data_q      <= data_nxt;
         underrun_q  <= underrun_nxt;
         frame_cnt_q <= frame_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      word_cnt_nxt  = word_cnt;
      data_nxt      = data_q;
      underrun_nxt  = 1'b0;
      frame_cnt_nxt = frame_cnt_q;

      case (state)
         ST_RST: begin
            data_nxt = '0;
            // The hold time only accumulates while the link is enabled.
            if (!enable) begin
               cnt_nxt = '0;
            end else if (cnt == RST_LAST) begin
               state_nxt = ST_TRAIN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         ST_TRAIN: begin
            data_nxt = TRAIN_WORD;
            if (!enable) begin
               state_nxt = ST_RST;
               cnt_nxt   = '0;
            end else if (cnt == TRAIN_LAST) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         ST_IDLE: begin
            data_nxt = IDLE_WORD;
            cnt_nxt  = '0;
            // Disable has priority over starting a frame; s_valid is only
            // observed here, not consumed.
            if (!enable) begin
               state_nxt = ST_RST;
            end else if (s_valid) begin
               state_nxt = ST_SYNC;
            end
         end

         ST_SYNC: begin
            data_nxt     = SYNC_WORD;
            state_nxt    = ST_FRAME;
            word_cnt_nxt = '0;
         end

         ST_FRAME: begin
            // A started frame always completes, regardless of enable.
            if (s_valid) begin
               data_nxt = s_data;
               if (word_cnt == WORD_LAST) begin
                  state_nxt     = ST_IDLE;
                  word_cnt_nxt  = '0;
                  frame_cnt_nxt = frame_cnt_q + 16'd1;
               end else begin
                  word_cnt_nxt = word_cnt + 1'b1;
               end
            end else begin
               data_nxt     = IDLE_WORD;
               underrun_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt = ST_RST;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule
